// File: rtl/mlu_writeback.sv
// Tile write-back streamer: captures four shaded RGB tiles and emits them as 96 32-bit words.
// Optional feature macro: MLU_WB_CHECKSUM_EN (XOR checksum of emitted words; tied to 0 when undefined).
module mlu_writeback #(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [255:0]      next_reds0,
   input  logic [255:0]      next_reds1,
   input  logic [255:0]      next_reds2,
   input  logic [255:0]      next_reds3,
   input  logic [255:0]      next_greens0,
   input  logic [255:0]      next_greens1,
   input  logic [255:0]      next_greens2,
   input  logic [255:0]      next_greens3,
   input  logic [255:0]      next_blues0,
   input  logic [255:0]      next_blues1,
   input  logic [255:0]      next_blues2,
   input  logic [255:0]      next_blues3,
   output logic              busy,
   output logic              done,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic [31:0]       checksum
);

   localparam int         WORDS    = 96;
   localparam int         REST_W   = (WORDS - 1) * 32;
   localparam logic [6:0] LAST_IDX = 7'd95;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   state_t            state_r;
   logic [6:0]        idx_r;
   logic              wr_valid_r;
   logic              done_r;
   logic [ADDR_W-1:0] wr_addr_r;
   logic [31:0]       wr_data_r;
   // Words 1..95 still to be emitted, oldest in the low 32 bits.
   logic [REST_W-1:0] rest_r;

   logic accept_s;
   logic hs_s;

   // Start acceptance and write handshake qualifiers.
   always_comb begin
      accept_s = 1'b0;
      hs_s     = 1'b0;
      if (state_r == IDLE) begin
         accept_s = start;
      end else begin
         hs_s = wr_valid_r & wr_ready;
      end
   end

   // Control FSM with registered write-port and done outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         idx_r      <= 7'd0;
         wr_valid_r <= 1'b0;
         done_r     <= 1'b0;
         wr_addr_r  <= {ADDR_W{1'b0}};
         wr_data_r  <= 32'd0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (accept_s) begin
                  state_r    <= STREAM;
                  idx_r      <= 7'd0;
                  wr_valid_r <= 1'b1;
                  wr_addr_r  <= base_addr;
                  wr_data_r  <= next_reds0[31:0];
               end
            end
            STREAM: begin
               done_r <= 1'b0;
               if (hs_s) begin
                  if (idx_r == LAST_IDX) begin
                     state_r    <= IDLE;
                     idx_r      <= 7'd0;
                     wr_valid_r <= 1'b0;
                     done_r     <= 1'b1;
                  end else begin
                     idx_r     <= idx_r + 7'd1;
                     wr_addr_r <= wr_addr_r + ADDR_W'(1);
                     wr_data_r <= rest_r[31:0];
                  end
               end
            end
            default: begin
               state_r    <= IDLE;
               idx_r      <= 7'd0;
               wr_valid_r <= 1'b0;
               done_r     <= 1'b0;
            end
         endcase
      end
   end

   // Capture buffer: no reset needed, it only feeds wr_data while streaming.
   always_ff @(posedge clk) begin
      if (accept_s) begin
         rest_r <= {next_blues3, next_greens3, next_reds3,
                    next_blues2, next_greens2, next_reds2,
                    next_blues1, next_greens1, next_reds1,
                    next_blues0, next_greens0, next_reds0[255:32]};
      end else if (hs_s) begin
         rest_r <= {32'd0, rest_r[REST_W-1:32]};
      end
   end

`ifdef MLU_WB_CHECKSUM_EN
   logic [31:0] checksum_r;

   // XOR accumulator over accepted words, cleared by each accepted start.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         checksum_r <= 32'd0;
      end else if (accept_s) begin
         checksum_r <= 32'd0;
      end else if (hs_s) begin
         checksum_r <= checksum_r ^ wr_data_r;
      end
   end

   assign checksum = checksum_r;
`else
   assign checksum = 32'd0;
`endif

   assign busy     = (state_r == STREAM);
   assign done     = done_r;
   assign wr_valid = wr_valid_r;
   assign wr_addr  = wr_addr_r;
   assign wr_data  = wr_data_r;

endmodule

// File: tb/tb_mlu_writeback.sv
// Randomized self-checking bench for mlu_writeback against a word-order reference model.
module tb_mlu_writeback;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] base_addr;
   logic [255:0] reds [4];
   logic [255:0] greens [4];
   logic [255:0] blues [4];
   logic        busy, done, wr_valid, wr_ready;
   logic [15:0] wr_addr;
   logic [31:0] wr_data, checksum;

   logic [255:0] cap_r [4];
   logic [255:0] cap_g [4];
   logic [255:0] cap_b [4];
   logic [31:0]  exp_ck;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mlu_writeback #(.ADDR_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .next_reds0(reds[0]), .next_reds1(reds[1]), .next_reds2(reds[2]), .next_reds3(reds[3]),
      .next_greens0(greens[0]), .next_greens1(greens[1]),
      .next_greens2(greens[2]), .next_greens3(greens[3]),
      .next_blues0(blues[0]), .next_blues1(blues[1]),
      .next_blues2(blues[2]), .next_blues3(blues[3]),
      .busy(busy), .done(done), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_addr(wr_addr), .wr_data(wr_data), .checksum(checksum)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Word k: tile k/24, channel (k%24)/8, 32-bit slice k%8 of that plane.
   function automatic logic [31:0] model_word(input int k);
      int t = k / 24;
      int c = (k % 24) / 8;
      int j = k % 8;
      logic [255:0] p;
      case (c)
         0:       p = cap_r[t];
         1:       p = cap_g[t];
         default: p = cap_b[t];
      endcase
      return p[32*j +: 32];
   endfunction

   task automatic rand_plane(output logic [255:0] p);
      for (int i = 0; i < 8; i++) p[32*i +: 32] = $urandom;
   endtask

   // kind 0 random, 1 all ones, 2 only blues3 slice 7 set, 3 random with reds0 = DEADBEEF
   task automatic set_planes(input int kind);
      for (int t = 0; t < 4; t++) begin
         case (kind)
            1: begin reds[t] = '1; greens[t] = '1; blues[t] = '1; end
            2: begin reds[t] = '0; greens[t] = '0; blues[t] = '0; end
            default: begin rand_plane(reds[t]); rand_plane(greens[t]); rand_plane(blues[t]); end
         endcase
      end
      if (kind == 2) blues[3][255:224] = 32'h12345678;
      if (kind == 3) reds[0] = 256'hDEADBEEF;
   endtask

   task automatic idle_check(input string tag);
      @(posedge clk); #1;
      check_eq({tag, "_done"}, 32'(done), 32'd0);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_valid"}, 32'(wr_valid), 32'd0);
      check_eq({tag, "_ck"}, checksum, exp_ck);
   endtask

   // Called #1 after an edge with the DUT idle or in its done cycle; returns in the done cycle
   // (or one cycle after a mid-stream reset when rst_at hits).
   task automatic stream(input logic [15:0] base, input int stall_at, input bit rand_ready,
                         input bit collide, input int rst_at);
      int k = 0;
      int stall = 0;
      int cyc = 0;
      logic [31:0] xs = 32'd0;
      logic [15:0] ea;
      cap_r = reds; cap_g = greens; cap_b = blues;
      start = 1'b1; base_addr = base; wr_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; base_addr = 16'($urandom);
      set_planes(0);
      check_eq("first_busy", 32'(busy), 32'd1);
      while (k < 96 && cyc < 1000) begin
         cyc++;
         ea = base + 16'(k);
         check_eq("valid", 32'(wr_valid), 32'd1);
         check_eq("addr", 32'(wr_addr), 32'(ea));
         check_eq("data", wr_data, model_word(k));
         if (k == rst_at) begin
            rst_n = 1'b0; start = 1'b1;
            @(posedge clk); #1;
            rst_n = 1'b1; start = 1'b0;
            exp_ck = 32'd0;
            check_eq("rst_valid", 32'(wr_valid), 32'd0);
            check_eq("rst_busy", 32'(busy), 32'd0);
            check_eq("rst_done", 32'(done), 32'd0);
            check_eq("rst_addr", 32'(wr_addr), 32'd0);
            check_eq("rst_data", wr_data, 32'd0);
            check_eq("rst_ck", checksum, 32'd0);
            idle_check("rst_idle");
            return;
         end
         if (k == stall_at && stall < 5) begin
            wr_ready = 1'b0;
            stall++;
         end else if (rand_ready && k != 95) begin
            wr_ready = ($urandom_range(0, 2) != 0);
         end else begin
            wr_ready = 1'b1;
         end
         start = collide && wr_ready && (k == 40 || k == 95);
         base_addr = 16'($urandom);
         @(posedge clk); #1;
         start = 1'b0;
         if (wr_ready) begin
            xs ^= model_word(k);
            k++;
         end
      end
      check_eq("word_count", 32'(k), 32'd96);
      if (stall_at >= 0) check_eq("stall_cycles", 32'(stall), 32'd5);
`ifdef MLU_WB_CHECKSUM_EN
      exp_ck = xs;
`else
      exp_ck = 32'd0;
`endif
      check_eq("done", 32'(done), 32'd1);
      check_eq("end_valid", 32'(wr_valid), 32'd0);
      check_eq("end_busy", 32'(busy), 32'd0);
      check_eq("end_ck", checksum, exp_ck);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b1; wr_ready = 1'b1; base_addr = 16'h5555; exp_ck = 32'd0;
      set_planes(0);
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset_valid", 32'(wr_valid), 32'd0);
      check_eq("reset_busy", 32'(busy), 32'd0);
      check_eq("reset_done", 32'(done), 32'd0);
      check_eq("reset_addr", 32'(wr_addr), 32'd0);
      check_eq("reset_data", wr_data, 32'd0);
      check_eq("reset_ck", checksum, 32'd0);
      rst_n = 1'b1; start = 1'b0;
      idle_check("post_reset");

      set_planes(3);
      stream(16'h0100, -1, 1'b0, 1'b0, -1);
      idle_check("basic");

      set_planes(0);
      stream(16'h1234, 8, 1'b0, 1'b0, -1);
      idle_check("stall");

      set_planes(0);
      stream(16'hFFF0, -1, 1'b1, 1'b0, -1);
      idle_check("wrap");

      set_planes(0);
      stream(16'($urandom), -1, 1'b0, 1'b1, -1);
      idle_check("collide");

      set_planes(0);
      stream(16'($urandom), -1, 1'b1, 1'b0, -1);
      set_planes(0);
      stream(16'($urandom), -1, 1'b0, 1'b0, -1);
      idle_check("b2b");

      set_planes(0);
      stream(16'h2000, -1, 1'b0, 1'b0, 50);
      set_planes(0);
      stream(16'h3000, -1, 1'b0, 1'b0, -1);
      idle_check("after_rst");

      set_planes(1);
      stream(16'h4000, -1, 1'b0, 1'b0, -1);
      idle_check("ck_ones");
      set_planes(2);
      stream(16'h4100, -1, 1'b1, 1'b0, -1);
      idle_check("ck_single");

      for (int i = 0; i < 3; i++) begin
         set_planes(0);
         stream(16'($urandom), int'($urandom_range(0, 95)), 1'b1, 1'b0, -1);
         idle_check("random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
